// File: rtl/vc_arbiter.sv
// vc_arbiter: weighted VC0/VC1 scheduler feeding one downstream FIFO.
// Read strobes are registered. Returned words pass through a two-stage pipe
// and are tagged with their source channel. A credit counter mirrors the free
// space in the downstream FIFO, so pushes can never overflow it.
module vc_arbiter #(
   parameter int data_width = 6,
   parameter int VC0_WEIGHT = 4,
   parameter int DEST_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  empty_fifo_VC0,
   input  logic                  empty_fifo_VC1,
   input  logic                  almost_empty_fifo_VC0,
   input  logic                  almost_empty_fifo_VC1,
   input  logic [data_width-1:0] data_out_VC0,
   input  logic [data_width-1:0] data_out_VC1,
   input  logic                  dest_rd_enable,
   output logic                  rd_enable_VC0,
   output logic                  rd_enable_VC1,
   output logic                  valid_out,
   output logic [data_width-1:0] data_out,
   output logic                  vc_id_out,
   output logic [7:0]            credits,
   output logic                  credit_error,
   output logic                  idle
);

   localparam logic [7:0] DEPTH8  = 8'(DEST_DEPTH);
   localparam logic [3:0] WEIGHT4 = 4'(VC0_WEIGHT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   state_t     state;
   state_t     state_next;

   logic       elig_vc0;
   logic       elig_vc1;
   logic       can_issue;
   logic       grant_vc0;
   logic       grant_vc1;
   logic       issue;
   logic       overflow;
   logic [3:0] streak;
   logic [3:0] streak_next;
   logic [7:0] credits_next;
   logic       s1_valid;
   logic       s1_vc;

   // Next-state logic; DRAIN waits until both pipe stages are empty.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:   if (enable) state_next = ST_ACTIVE;
         ST_ACTIVE: if (!enable) state_next = ST_DRAIN;
         ST_DRAIN: begin
            if (enable)
               state_next = ST_ACTIVE;
            else if (!s1_valid && !valid_out)
               state_next = ST_IDLE;
         end
         default:   state_next = ST_IDLE;
      endcase
   end

   // Eligibility and weighted grant. A FIFO holding one word that is already
   // being read is treated as empty, because its count lags the strobe by a cycle.
   // Grants are also gated by enable, so dropping enable stops strobes at once.
   always_comb begin
      elig_vc0  = !empty_fifo_VC0 && !(rd_enable_VC0 && almost_empty_fifo_VC0);
      elig_vc1  = !empty_fifo_VC1 && !(rd_enable_VC1 && almost_empty_fifo_VC1);
      can_issue = (state == ST_ACTIVE) && enable && (credits != 8'd0);
      grant_vc1 = can_issue && elig_vc1 && (!elig_vc0 || (streak == WEIGHT4));
      grant_vc0 = can_issue && elig_vc0 && !grant_vc1;
      issue     = grant_vc0 || grant_vc1;
   end

   // Streak and credit bookkeeping. A return while the counter is already full
   // is an upstream protocol error: the counter holds and the error is flagged.
   always_comb begin
      streak_next = streak;
      if (grant_vc1)
         streak_next = 4'd0;
      else if (grant_vc0 && (streak != WEIGHT4))
         streak_next = streak + 4'd1;

      overflow     = dest_rd_enable && (credits == DEPTH8);
      credits_next = credits;
      if (issue && !dest_rd_enable)
         credits_next = credits - 8'd1;
      else if (dest_rd_enable && !issue && !overflow)
         credits_next = credits + 8'd1;
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // Registered read strobes, streak counter, credits and the sticky error flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_enable_VC0 <= 1'b0;
         rd_enable_VC1 <= 1'b0;
         streak        <= 4'd0;
         credits       <= DEPTH8;
         credit_error  <= 1'b0;
      end else begin
         rd_enable_VC0 <= grant_vc0;
         rd_enable_VC1 <= grant_vc1;
         streak        <= streak_next;
         credits       <= credits_next;
         if (overflow)
            credit_error <= 1'b1;
      end
   end

   // Return pipe: stage 1 remembers which FIFO was strobed. Stage 2 captures
   // that FIFO's data the cycle it is presented; payload holds between pushes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid  <= 1'b0;
         s1_vc     <= 1'b0;
         valid_out <= 1'b0;
         vc_id_out <= 1'b0;
         data_out  <= '0;
      end else begin
         s1_valid  <= rd_enable_VC0 || rd_enable_VC1;
         s1_vc     <= rd_enable_VC1;
         valid_out <= s1_valid;
         if (s1_valid) begin
            vc_id_out <= s1_vc;
            data_out  <= s1_vc ? data_out_VC1 : data_out_VC0;
         end
      end
   end

   assign idle = (state == ST_IDLE);

endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: randomized bench with a behavioural scheduler model.
// VC FIFOs are modelled as queues. Expected pushes go into a scoreboard that
// a separate monitor drains on every valid_out.
module tb_vc_arbiter;

   localparam int DW     = 6;
   localparam int WEIGHT = 4;
   localparam int DEPTH  = 16;

   typedef enum int {M_IDLE, M_ACTIVE, M_DRAIN} mode_t;
   typedef struct {
      int due;
      int vc;
      int data;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          empty_fifo_VC0 = 1'b1;
   logic          empty_fifo_VC1 = 1'b1;
   logic          almost_empty_fifo_VC0 = 1'b0;
   logic          almost_empty_fifo_VC1 = 1'b0;
   logic [DW-1:0] data_out_VC0 = '0;
   logic [DW-1:0] data_out_VC1 = '0;
   logic          dest_rd_enable = 1'b0;
   logic          rd_enable_VC0;
   logic          rd_enable_VC1;
   logic          valid_out;
   logic [DW-1:0] data_out;
   logic          vc_id_out;
   logic [7:0]    credits;
   logic          credit_error;
   logic          idle;

   vc_arbiter #(
      .data_width(DW),
      .VC0_WEIGHT(WEIGHT),
      .DEST_DEPTH(DEPTH)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .enable                (enable),
      .empty_fifo_VC0        (empty_fifo_VC0),
      .empty_fifo_VC1        (empty_fifo_VC1),
      .almost_empty_fifo_VC0 (almost_empty_fifo_VC0),
      .almost_empty_fifo_VC1 (almost_empty_fifo_VC1),
      .data_out_VC0          (data_out_VC0),
      .data_out_VC1          (data_out_VC1),
      .dest_rd_enable        (dest_rd_enable),
      .rd_enable_VC0         (rd_enable_VC0),
      .rd_enable_VC1         (rd_enable_VC1),
      .valid_out             (valid_out),
      .data_out              (data_out),
      .vc_id_out             (vc_id_out),
      .credits               (credits),
      .credit_error          (credit_error),
      .idle                  (idle)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int    n_chk  = 0;
   int    n_fail = 0;

   // VC FIFO contents and scoreboard
   int    q0[$];
   int    q1[$];
   exp_t  sb[$];
   int    last_d  = 0;
   int    last_vc = 0;
   bit    s0_cap  = 1'b0;
   bit    s1_cap  = 1'b0;

   // behavioural model state
   mode_t m_mode   = M_IDLE;
   int    m_cred   = DEPTH;
   bit    m_err    = 1'b0;
   int    m_streak = 0;
   bit    m_out0   = 1'b0;
   bit    m_out1   = 1'b0;
   int    m_dues[$];

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic upd_flags();
      empty_fifo_VC0        = (q0.size() == 0);
      empty_fifo_VC1        = (q1.size() == 0);
      almost_empty_fifo_VC0 = (q0.size() == 1);
      almost_empty_fifo_VC1 = (q1.size() == 1);
   endtask

   // Output monitor: pops one expected word per push, checks hold otherwise.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (valid_out) begin
               if (sb.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_push: got data %0d vc %0d expected no push (cycle %0d)",
                           data_out, vc_id_out, cyc);
               end else begin
                  e = sb.pop_front();
                  chk("push_cycle", cyc, e.due);
                  chk("vc_id_out", int'(vc_id_out), e.vc);
                  chk("data_out", int'(data_out), e.data);
                  last_d  = e.data;
                  last_vc = e.vc;
               end
               $display("push cycle %0d vc %0d data %0d", cyc, vc_id_out, data_out);
            end else begin
               chk("data_hold", int'(data_out), last_d);
               chk("vc_hold", int'(vc_id_out), last_vc);
            end
         end
      end
   end

   // Asynchronous reset mid-cycle; outputs must clear at once.
   task automatic do_reset();
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("rst_rd_enable_VC0", int'(rd_enable_VC0), 0);
      chk("rst_rd_enable_VC1", int'(rd_enable_VC1), 0);
      chk("rst_valid_out", int'(valid_out), 0);
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_vc_id_out", int'(vc_id_out), 0);
      chk("rst_credits", int'(credits), DEPTH);
      chk("rst_credit_error", int'(credit_error), 0);
      chk("rst_idle", int'(idle), 1);
      m_mode   = M_IDLE;
      m_cred   = DEPTH;
      m_err    = 1'b0;
      m_streak = 0;
      m_out0   = 1'b0;
      m_out1   = 1'b0;
      m_dues.delete();
      sb.delete();
      last_d   = 0;
      last_vc  = 0;
      s0_cap   = 1'b0;
      s1_cap   = 1'b0;
      enable         = 1'b0;
      dest_rd_enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // One clock of stimulus + model. Entered and left at a falling edge.
   task automatic step(int pe, int pr, int p0, int p1, bit allow_over);
      int    g;
      int    w;
      bit    ret;
      bit    e0;
      bit    e1;
      bit    inflight;
      bit    vexp;
      mode_t n_mode;
      int    n_cred;
      int    n_streak;

      while (m_dues.size() > 0 && m_dues[0] < cyc) void'(m_dues.pop_front());
      vexp = (m_dues.size() > 0) && (m_dues[0] == cyc);
      chk("rd_enable_VC0", int'(rd_enable_VC0), int'(m_out0));
      chk("rd_enable_VC1", int'(rd_enable_VC1), int'(m_out1));
      chk("valid_out", int'(valid_out), int'(vexp));
      chk("credits", int'(credits), m_cred);
      chk("credit_error", int'(credit_error), int'(m_err));
      chk("idle", int'(idle), int'(m_mode == M_IDLE));
      s0_cap = rd_enable_VC0;
      s1_cap = rd_enable_VC1;

      enable = ($urandom_range(0, 99) < pe);
      ret    = ($urandom_range(0, 99) < pr) && (allow_over || m_cred < DEPTH);
      dest_rd_enable = ret;
      if ($urandom_range(0, 99) < p0 && q0.size() < 24) q0.push_back(int'($urandom_range(0, 63)));
      if ($urandom_range(0, 99) < p1 && q1.size() < 24) q1.push_back(int'($urandom_range(0, 63)));
      upd_flags();

      inflight = (m_dues.size() > 0);
      g = -1;
      if (m_mode == M_ACTIVE && enable && m_cred > 0) begin
         // words not yet claimed by an outstanding strobe
         e0 = q0.size() > int'(m_out0);
         e1 = q1.size() > int'(m_out1);
         if (e0 && e1)  g = (m_streak == WEIGHT) ? 1 : 0;
         else if (e0)   g = 0;
         else if (e1)   g = 1;
      end

      n_streak = m_streak;
      if (g == 0) begin
         w = q0[m_out0 ? 1 : 0];
         n_streak = (m_streak < WEIGHT) ? m_streak + 1 : WEIGHT;
      end else if (g == 1) begin
         w = q1[m_out1 ? 1 : 0];
         n_streak = 0;
      end
      if (g >= 0) begin
         sb.push_back('{cyc + 3, g, w});
         m_dues.push_back(cyc + 3);
      end

      if (g >= 0 && !ret)       n_cred = m_cred - 1;
      else if (ret && g < 0)    n_cred = (m_cred == DEPTH) ? DEPTH : m_cred + 1;
      else                      n_cred = m_cred;

      case (m_mode)
         M_IDLE:   n_mode = enable ? M_ACTIVE : M_IDLE;
         M_ACTIVE: n_mode = enable ? M_ACTIVE : M_DRAIN;
         default:  n_mode = enable ? M_ACTIVE : (inflight ? M_DRAIN : M_IDLE);
      endcase

      @(posedge clk);
      #1;
      if (s0_cap && q0.size() > 0) data_out_VC0 = DW'(q0.pop_front());
      if (s1_cap && q1.size() > 0) data_out_VC1 = DW'(q1.pop_front());
      upd_flags();
      m_err    = m_err | (ret && m_cred == DEPTH);
      m_cred   = n_cred;
      m_streak = n_streak;
      m_mode   = n_mode;
      m_out0   = (g == 0);
      m_out1   = (g == 1);
      @(negedge clk);
   endtask

   initial begin
      do_reset();

      // single VC0 stream of three words
      q0.push_back(10);
      q0.push_back(21);
      q0.push_back(42);
      upd_flags();
      repeat (10) step(100, 0, 0, 0, 0);

      // both channels backlogged: weighted pattern
      repeat (12) begin
         q0.push_back(int'($urandom_range(0, 63)));
         q1.push_back(int'($urandom_range(0, 63)));
      end
      upd_flags();
      repeat (40) step(100, 100, 90, 90, 0);

      // refill credits, then exhaust them, then release exactly one
      repeat (6)  step(0, 100, 0, 0, 0);
      repeat (30) step(100, 0, 70, 0, 0);
      step(100, 100, 70, 0, 0);
      repeat (6)  step(100, 0, 70, 0, 0);
      repeat (20) step(100, 100, 50, 50, 0);

      // random traffic, then frequent enable toggling (drain / re-activate)
      repeat (300) step(70, 50, 40, 40, 0);
      repeat (200) step(50, 50, 50, 50, 0);

      // reset in the middle of traffic
      repeat (5) step(100, 0, 90, 90, 0);
      do_reset();

      // credit returns while full set the sticky error
      repeat (4) step(0, 100, 0, 0, 1);
      repeat (200) step(70, 60, 50, 50, 1);

      // final drain
      repeat (20) step(0, 0, 0, 0, 0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
